// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM geometry defaults and sequencer state encoding
package ram_pkg;

    localparam int ADDR_SIZE_DEF = 10;
    localparam int WORD_SIZE_DEF = 8;
    localparam int LEN_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_seq_master_if.sv
// rtl/ram_seq_master_if.sv - command, write/read stream and RAM pin bundle for the burst sequencer
interface ram_seq_master_if
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int LEN_W     = LEN_W_DEF
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [LEN_W-1:0]     cmd_len;

    logic                 wdata_valid;
    logic                 wdata_ready;
    logic [WORD_SIZE-1:0] wdata;

    logic                 rdata_valid;
    logic                 rdata_ready;
    logic [WORD_SIZE-1:0] rdata;

    logic                 done;

    logic                 ram_cs;
    logic                 ram_wr;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_din;
    logic [WORD_SIZE-1:0] ram_dout;

    // master: the sequencer itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready, ram_dout,
        output cmd_ready, wdata_ready, rdata_valid, rdata, done,
        output ram_cs, ram_wr, ram_addr, ram_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready, ram_dout,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, done,
        input  ram_cs, ram_wr, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_seq_addr_cnt.sv
// rtl/ram_seq_addr_cnt.sv - wrapping address pointer plus beat down-counter with last-beat flag
module ram_seq_addr_cnt
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic [ADDR_SIZE-1:0] ptr_o,
    output logic [ADDR_SIZE-1:0] ptr_inc_o,
    output logic                 last_o
);

    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    assign ptr_o     = ptr_q;
    assign ptr_inc_o = ptr_q + 1'b1;
    // cnt holds beats still to go minus one, so zero marks the final beat
    assign last_o    = (cnt_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ptr_d = addr_i;
            cnt_d = len_i;
        end else if (step_i) begin
            ptr_d = ptr_inc_o;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_seq_master.sv
// rtl/ram_seq_master.sv - burst sequencer driving a single-port RAM from stream-style write/read ports
module ram_seq_master
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    ram_seq_master_if.master bus
);

    state_t               state_q;
    logic                 cmd_ready_q;
    logic                 wdata_ready_q;
    logic                 rdata_valid_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 done_q;
    logic                 ram_cs_q;
    logic                 ram_wr_q;
    logic [ADDR_SIZE-1:0] ram_addr_q;
    logic [WORD_SIZE-1:0] ram_din_q;
    logic                 wr_last_q;
    logic                 rd_last_q;

    logic                 cmd_hs;
    logic                 wr_acc;
    logic                 rd_cap;
    logic [ADDR_SIZE-1:0] ptr;
    logic [ADDR_SIZE-1:0] ptr_inc;
    logic                 last_beat;

    assign cmd_hs = bus.cmd_valid && cmd_ready_q;
    assign wr_acc = (state_q == ST_WRITE) && bus.wdata_valid && wdata_ready_q;
    // rd_last_q means the final beat is already held, so stop fetching
    assign rd_cap = (state_q == ST_READ) && !rd_last_q && (!rdata_valid_q || bus.rdata_ready);

    ram_seq_addr_cnt #(
        .ADDR_SIZE (ADDR_SIZE),
        .LEN_W     (LEN_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cmd_hs),
        .step_i    (wr_acc || rd_cap),
        .addr_i    (bus.cmd_addr),
        .len_i     (bus.cmd_len),
        .ptr_o     (ptr),
        .ptr_inc_o (ptr_inc),
        .last_o    (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            ram_cs_q      <= 1'b0;
            ram_wr_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
            wr_last_q     <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ram_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        ram_cs_q    <= 1'b1;
                        ram_addr_q  <= bus.cmd_addr;
                        wr_last_q   <= 1'b0;
                        rd_last_q   <= 1'b0;
                        if (bus.cmd_write) begin
                            state_q       <= ST_WRITE;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_last_q) begin
                        state_q  <= ST_DONE;
                        ram_cs_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (wr_acc) begin
                        ram_wr_q   <= 1'b1;
                        ram_addr_q <= ptr;
                        ram_din_q  <= bus.wdata;
                        if (last_beat) begin
                            wdata_ready_q <= 1'b0;
                            wr_last_q     <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_last_q && bus.rdata_ready) begin
                        state_q       <= ST_DONE;
                        rdata_valid_q <= 1'b0;
                        ram_cs_q      <= 1'b0;
                        done_q        <= 1'b1;
                    end else if (rd_cap) begin
                        rdata_q       <= bus.ram_dout;
                        rdata_valid_q <= 1'b1;
                        ram_addr_q    <= ptr_inc;
                        if (last_beat) begin
                            rd_last_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.ram_cs      = ram_cs_q;
    assign bus.ram_wr      = ram_wr_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;

endmodule

// File: tb/tb_ram_seq_master.sv
// tb/tb_ram_seq_master.sv - directed burst vectors against ram_seq_master with a behavioural RAM
module tb_ram_seq_master;
    import ram_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_seq_master_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .LEN_W(LW)) bus ();

    ram_seq_master #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] exp_mem [0:1023];

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_wr) mem[bus.ram_addr] <= bus.ram_din;
    end
    assign bus.ram_dout = mem[bus.ram_addr];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [7:0]  len;
        logic [31:0] d;
        int          gap;
        logic [3:0]  pat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] beat_data(input logic [31:0] d, input int i);
        return d[8*(i%4) +: 8] + 8'(i & ~3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_ready(input string nm);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " cmd_ready"}, bus.cmd_ready, 1);
    endtask

    task automatic do_write(input string nm, input logic [9:0] a, input logic [7:0] len,
                            input logic [31:0] d, input int gap);
        int nb = int'(len) + 1;
        int acc_n = 0, wr_n = 0, done_n = 0, done_cyc = -1, last_acc = -1;
        int wr_bad = 0, data_bad = 0, rdy_bad = 0, mem_bad = 0;
        logic prev_acc = 1'b0;
        logic [9:0] wa;
        for (int i = 0; i < nb; i++) begin
            wa = a + 10'(i);
            exp_mem[wa] = beat_data(d, i);
        end
        wait_cmd_ready(nm);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k < nb * gap + 20; k++) begin
            if (bus.ram_wr !== prev_acc) wr_bad++;
            if (bus.ram_wr) begin
                wa = a + 10'(wr_n);
                if (bus.ram_addr !== wa || bus.ram_din !== beat_data(d, wr_n)) data_bad++;
                wr_n++;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = k;
                break;
            end
            if (bus.cmd_ready) rdy_bad++;
            if (acc_n < nb && (k % gap) == 0) begin
                bus.wdata_valid = 1'b1;
                bus.wdata       = beat_data(d, acc_n);
            end else begin
                bus.wdata_valid = 1'b0;
            end
            prev_acc = bus.wdata_valid && bus.wdata_ready;
            if (prev_acc) begin
                acc_n++;
                last_acc = k;
            end
            tick();
        end
        bus.wdata_valid = 1'b0;
        chk({nm, " ram_wr pattern"}, wr_bad, 0);
        chk({nm, " write addr/data"}, data_bad, 0);
        chk({nm, " write count"}, wr_n, nb);
        chk({nm, " done count"}, done_n, 1);
        chk({nm, " done latency"}, done_cyc, last_acc + 2);
        chk({nm, " cmd_ready busy"}, rdy_bad, 0);
        tick();
        chk({nm, " done width"}, bus.done, 0);
        for (int i = 0; i < nb; i++) begin
            wa = a + 10'(i);
            if (mem[wa] !== exp_mem[wa]) mem_bad++;
        end
        chk({nm, " ram contents"}, mem_bad, 0);
    endtask

    task automatic do_read(input string nm, input logic [9:0] a, input logic [7:0] len,
                           input logic [3:0] pat);
        int nb = int'(len) + 1;
        int nacc = 0, first_v = -1, last_acc = -1, done_n = 0, done_cyc = -1;
        int stall_bad = 0, data_bad = 0, ptr_bad = 0, wr_bad = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic [9:0] wa;
        wait_cmd_ready(nm);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k < nb * 4 + 20; k++) begin
            if (bus.ram_wr) wr_bad++;
            if (bus.done) begin
                done_n++;
                done_cyc = k;
                break;
            end
            if (prev_stall && (!bus.rdata_valid || bus.rdata !== prev_data)) stall_bad++;
            if (bus.rdata_valid && first_v < 0) first_v = k;
            wa = a + 10'(nacc) + (bus.rdata_valid ? 10'd1 : 10'd0);
            if (bus.ram_addr !== wa) ptr_bad++;
            bus.rdata_ready = pat[k % 4];
            if (bus.rdata_valid && bus.rdata_ready) begin
                wa = a + 10'(nacc);
                if (bus.rdata !== exp_mem[wa]) data_bad++;
                nacc++;
                last_acc = k;
            end
            prev_stall = bus.rdata_valid && !bus.rdata_ready;
            prev_data  = bus.rdata;
            tick();
        end
        bus.rdata_ready = 1'b0;
        chk({nm, " beats accepted"}, nacc, nb);
        chk({nm, " first valid"}, first_v, 2);
        chk({nm, " read data"}, data_bad, 0);
        chk({nm, " stall hold"}, stall_bad, 0);
        chk({nm, " ptr tracking"}, ptr_bad, 0);
        chk({nm, " no ram_wr"}, wr_bad, 0);
        chk({nm, " done count"}, done_n, 1);
        chk({nm, " done latency"}, done_cyc, last_acc + 1);
        if (pat == 4'hF) chk({nm, " throughput"}, last_acc, nb + 1);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;

        vecs[0] = '{1'b1, 10'h010, 8'd3,   32'hA3A2A1A0, 1, 4'hF};
        vecs[1] = '{1'b0, 10'h010, 8'd3,   32'h0,        1, 4'hF};
        vecs[2] = '{1'b0, 10'h010, 8'd3,   32'h0,        1, 4'b1001};
        vecs[3] = '{1'b1, 10'h3FE, 8'd3,   32'h44332211, 1, 4'hF};
        vecs[4] = '{1'b0, 10'h3FE, 8'd3,   32'h0,        1, 4'hF};
        vecs[5] = '{1'b1, 10'h200, 8'd0,   32'h0000005A, 3, 4'hF};
        vecs[6] = '{1'b0, 10'h200, 8'd0,   32'h0,        1, 4'hF};
        vecs[7] = '{1'b1, 10'h100, 8'd255, 32'h03020100, 1, 4'hF};
        vecs[8] = '{1'b0, 10'h100, 8'd255, 32'h0,        1, 4'hF};
        vecs[9] = '{1'b0, 10'h3FE, 8'd3,   32'h0,        1, 4'b0110};

        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd_ready", bus.cmd_ready, 0);
        chk("reset outputs", {bus.wdata_ready, bus.rdata_valid, bus.rdata, bus.done,
                              bus.ram_cs, bus.ram_wr, bus.ram_addr, bus.ram_din}, 0);
        rst = 1'b0;
        bus.wdata_valid = 1'b1;
        tick();
        chk("post-reset cmd_ready", bus.cmd_ready, 1);
        chk("idle wdata_ready", bus.wdata_ready, 0);
        chk("idle ram_wr", bus.ram_wr, 0);
        bus.wdata_valid = 1'b0;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr)
                do_write($sformatf("vec%0d wr", v), vecs[v].addr, vecs[v].len, vecs[v].d, vecs[v].gap);
            else
                do_read($sformatf("vec%0d rd", v), vecs[v].addr, vecs[v].len, vecs[v].pat);
        end

        // reset landing on the second beat of an 8-beat read
        wait_cmd_ready("rst seq");
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h010;
        bus.cmd_len   = 8'd7;
        tick();
        bus.cmd_valid   = 1'b0;
        bus.rdata_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            if (bus.rdata_valid) seen++;
            if (seen < 2) tick();
        end
        chk("rst seq second beat", seen, 2);
        chk("rst seq second beat data", bus.rdata, 8'hA1);
        rst = 1'b1;
        tick();
        chk("rst seq outputs", {bus.cmd_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata,
                                bus.done, bus.ram_cs, bus.ram_wr, bus.ram_addr, bus.ram_din}, 0);
        rst = 1'b0;
        bus.rdata_ready = 1'b0;
        tick();
        chk("rst seq cmd_ready", bus.cmd_ready, 1);
        chk("rst seq no done", bus.done, 0);
        do_read("after rst rd", 10'h3FE, 8'd3, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
